alien_fleet_controller: RTL and testbench



---
 rtl/alien_fleet_controller.sv | 134 +++++++++++++
 tb/tb_alien_fleet_controller.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alien_fleet_controller.sv
// Fleet-level control for the alien sprites: kill tracking, speed-up with kills,
// edge-triggered direction reversal and round-robin firing permission.
module alien_fleet_controller #(
  parameter int unsigned NUM_ALIENS     = 8,
  parameter logic [15:0] SPRITE_WIDTH   = 16'd16,
  parameter logic [15:0] LEFT_LIMIT     = 16'd8,
  parameter logic [15:0] RIGHT_LIMIT    = 16'd632,
  parameter logic [15:0] BASE_FREQUENCY = 16'd50000,
  parameter logic [15:0] SPEEDUP_STEP   = 16'd5000,
  parameter logic [15:0] MIN_FREQUENCY  = 16'd5000,
  parameter logic [23:0] FIRE_INTERVAL  = 24'd1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [16*NUM_ALIENS-1:0] position_x_flat,
  input  logic [NUM_ALIENS-1:0]    hit,
  input  logic                     respawn,
  output logic [NUM_ALIENS-1:0]    alive,
  output logic [NUM_ALIENS-1:0]    armed,
  output logic                     movement_direction,
  output logic [15:0]              movement_frequency,
  output logic [5:0]               kill_count,
  output logic                     fleet_cleared
);

  localparam int unsigned IDX_W = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;

  typedef enum logic {
    MOVE_LEFT  = 1'b0,
    MOVE_RIGHT = 1'b1
  } dir_t;

  dir_t               state, state_next;
  logic [23:0]        fire_timer;
  logic [IDX_W-1:0]   armed_idx, idx_next, sel_idx;
  logic [NUM_ALIENS-1:0] kills, alive_next, armed_next;
  logic [6:0]         pop, kill_sum;
  logic [5:0]         kill_next;
  logic [21:0]        product;
  logic [15:0]        freq_next;
  logic               at_right, at_left, wrap, found;
  logic [15:0]        px;
  logic [16:0]        right_edge;
  int unsigned        j;

  assign wrap = (fire_timer == FIRE_INTERVAL - 24'd1);

  always_comb begin
    kills      = hit & alive;
    alive_next = alive & ~hit;
    pop        = '0;
    for (int unsigned i = 0; i < NUM_ALIENS; i++) begin
      pop = pop + 7'(kills[i]);
    end
    kill_sum  = 7'(kill_count) + pop;
    kill_next = (kill_sum >= 7'(NUM_ALIENS)) ? 6'(NUM_ALIENS) : kill_sum[5:0];

    // Product cannot wrap in 22 bits (6-bit count x 16-bit step).
    product   = 22'(kill_count) * 22'(SPEEDUP_STEP);
    freq_next = (product >= 22'(BASE_FREQUENCY - MIN_FREQUENCY)) ?
                MIN_FREQUENCY : BASE_FREQUENCY - product[15:0];
  end

  always_comb begin
    at_right   = 1'b0;
    at_left    = 1'b0;
    px         = '0;
    right_edge = '0;
    for (int unsigned i = 0; i < NUM_ALIENS; i++) begin
      px         = position_x_flat[16*i +: 16];
      right_edge = {1'b0, px} + {1'b0, SPRITE_WIDTH};
      if (alive[i] && (right_edge >= {1'b0, RIGHT_LIMIT})) at_right = 1'b1;
      if (alive[i] && (px <= LEFT_LIMIT))                  at_left  = 1'b1;
    end

    state_next = state;
    case (state)
      MOVE_RIGHT: if (at_right) state_next = MOVE_LEFT;
      MOVE_LEFT:  if (at_left)  state_next = MOVE_RIGHT;
      default:    state_next = MOVE_RIGHT;
    endcase
  end

  // The index is kept even while armed is zero so the search resumes after
  // the killed alien rather than restarting at index 0.
  always_comb begin
    found   = 1'b0;
    sel_idx = armed_idx;
    j       = 0;
    for (int unsigned k = 1; k <= NUM_ALIENS; k++) begin
      j = 32'(armed_idx) + k;
      if (j >= NUM_ALIENS) j = j - NUM_ALIENS;
      if (!found && alive_next[j]) begin
        found   = 1'b1;
        sel_idx = j[IDX_W-1:0];
      end
    end

    armed_next = armed & alive_next;
    idx_next   = armed_idx;
    if (wrap) begin
      armed_next = '0;
      if (found) begin
        armed_next[sel_idx] = 1'b1;
        idx_next            = sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || respawn) begin
      state              <= MOVE_RIGHT;
      alive              <= '1;
      armed              <= NUM_ALIENS'(1);
      armed_idx          <= '0;
      kill_count         <= '0;
      movement_frequency <= BASE_FREQUENCY;
      fleet_cleared      <= 1'b0;
      fire_timer         <= '0;
    end else begin
      state              <= state_next;
      alive              <= alive_next;
      armed              <= armed_next;
      armed_idx          <= idx_next;
      kill_count         <= kill_next;
      movement_frequency <= freq_next;
      fleet_cleared      <= (alive == '0);
      fire_timer         <= wrap ? '0 : fire_timer + 24'd1;
    end
  end

  assign movement_direction = (state == MOVE_RIGHT);

endmodule

// File: tb/tb_alien_fleet_controller.sv
// Directed bench for alien_fleet_controller with a short fire interval; a second
// instance with a larger speed-up step exercises the frequency floor.
module tb_alien_fleet_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         respawn;
  logic [7:0]   hit;
  logic [127:0] pos;

  logic [7:0]   alive, armed, alive_f, armed_f;
  logic         dir, cleared, dir_f, cleared_f;
  logic [15:0]  freq, freq_f;
  logic [5:0]   kc, kc_f;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_armed;
  logic [7:0] seq [5];

  always #5 clk = ~clk;

  alien_fleet_controller #(.FIRE_INTERVAL(24'd4)) dut (
    .clk(clk), .rst(rst), .position_x_flat(pos), .hit(hit), .respawn(respawn),
    .alive(alive), .armed(armed), .movement_direction(dir),
    .movement_frequency(freq), .kill_count(kc), .fleet_cleared(cleared)
  );

  alien_fleet_controller #(.FIRE_INTERVAL(24'd4), .SPEEDUP_STEP(16'd7000)) dut_fast (
    .clk(clk), .rst(rst), .position_x_flat(pos), .hit(hit), .respawn(respawn),
    .alive(alive_f), .armed(armed_f), .movement_direction(dir_f),
    .movement_frequency(freq_f), .kill_count(kc_f), .fleet_cleared(cleared_f)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; respawn = 1'b0; hit = '0;
    for (int i = 0; i < 8; i++) pos[16*i +: 16] = 16'd100;
    tick(2);
    rst = 1'b0;
    chk("rst_alive", alive, 8'hFF);
    chk("rst_armed", armed, 8'h01);
    chk("rst_dir", dir, 1);
    chk("rst_freq", freq, 50000);
    chk("rst_kc", kc, 0);
    chk("rst_cleared", cleared, 0);

    // Edge reversal, including one-pixel-short boundaries
    pos[16*7 +: 16] = 16'd615; tick(1);
    chk("right_615_hold", dir, 1);
    pos[16*7 +: 16] = 16'd616; tick(1);
    chk("right_616_rev", dir, 0);
    pos[16*7 +: 16] = 16'd100; pos[0 +: 16] = 16'd9; tick(1);
    chk("left_9_hold", dir, 0);
    pos[0 +: 16] = 16'd8; tick(1);
    chk("left_8_rev", dir, 1);
    pos[0 +: 16] = 16'd100;
    hit = 8'h80; tick(1); hit = '0;
    pos[16*7 +: 16] = 16'd616; tick(2);
    chk("dead_no_rev", dir, 1);
    pos[16*7 +: 16] = 16'd100;

    // Simultaneous kills
    respawn = 1'b1; tick(1); respawn = 1'b0;
    chk("respawn_alive", alive, 8'hFF);
    hit = 8'h05; tick(1); hit = '0;
    chk("multi_alive", alive, 8'hFA);
    chk("multi_kc", kc, 2);
    chk("multi_freq_n1", freq, 50000);
    tick(1);
    chk("multi_freq_n2", freq, 40000);
    hit = 8'h01; tick(1); hit = '0;
    chk("rehit_alive", alive, 8'hFA);
    chk("rehit_kc", kc, 2);

    // Kill all one per cycle; frequency lags kill_count by one edge
    respawn = 1'b1; tick(1); respawn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hit = 8'(1 << i); tick(1);
      chk("sat_kc", kc, i + 1);
      chk("sat_freq", freq, 50000 - 5000 * i);
      chk("sat_freq_fast", freq_f, (i >= 7) ? 5000 : 50000 - 7000 * i);
    end
    hit = 8'hFF; tick(1); hit = '0;
    chk("sat_kc_final", kc, 8);
    chk("sat_freq_final", freq, 10000);
    chk("sat_freq_floor", freq_f, 5000);
    chk("sat_cleared", cleared, 1);
    chk("sat_armed", armed, 0);
    pos[16*7 +: 16] = 16'd616; tick(1);
    chk("empty_dir_hold", dir, 1);
    pos[16*7 +: 16] = 16'd100;

    // Armed rotation with aliens 1 and 2 dead; wraps every 4 edges after respawn
    respawn = 1'b1; tick(1); respawn = 1'b0;
    chk("rot_start", armed, 8'h01);
    hit = 8'h06; tick(1); hit = '0;
    tick(2);
    chk("rot_hold", armed, 8'h01);
    tick(1);
    chk("rot_first", armed, 8'h08);
    seq[0] = 8'h10; seq[1] = 8'h20; seq[2] = 8'h40; seq[3] = 8'h80; seq[4] = 8'h01;
    exp_armed = 8'h08;
    for (int s = 0; s < 5; s++) begin
      tick(3);
      chk("rot_steady", armed, exp_armed);
      tick(1);
      exp_armed = seq[s];
      chk("rot_next", armed, exp_armed);
    end
    hit = 8'h01; tick(1); hit = '0;
    chk("armed_killed", armed, 0);
    tick(2);
    chk("armed_zero_hold", armed, 0);
    tick(1);
    chk("armed_after_kill", armed, 8'h08);

    // Respawn wins over hit in the same cycle
    hit = 8'h05; tick(1); hit = '0;
    respawn = 1'b1; hit = 8'hFF; pos[16*7 +: 16] = 16'd616; tick(1);
    respawn = 1'b0; hit = '0; pos[16*7 +: 16] = 16'd100;
    chk("rsp_alive", alive, 8'hFF);
    chk("rsp_kc", kc, 0);
    chk("rsp_dir", dir, 1);
    chk("rsp_freq", freq, 50000);
    chk("rsp_armed", armed, 8'h01);
    chk("rsp_cleared", cleared, 0);
    tick(1);
    chk("rsp_freq_next", freq, 50000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
